// File: rtl/loop_uhat_sparse_row_acc.sv
// rtl/loop_uhat_sparse_row_acc.sv - sums multiplier products per sparse row, one result per row
module loop_uhat_sparse_row_acc #(
  parameter int PROD_WIDTH  = 54,
  parameter int ACC_WIDTH   = 64,
  parameter int MUL_LATENCY = 4,
  parameter int ROW_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic                  in_empty,
  output logic                  in_ready,
  output logic                  mul_ce,
  input  logic [PROD_WIDTH-1:0] mul_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [ROW_WIDTH-1:0]  out_row,
  output logic [ROW_WIDTH-1:0]  out_nnz,
  output logic                  out_ovf
);

  logic [MUL_LATENCY-1:0] tag_v;
  logic [MUL_LATENCY-1:0] tag_last;
  logic [MUL_LATENCY-1:0] tag_empty;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   addend;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic [ROW_WIDTH-1:0]   nnz;
  logic [ROW_WIDTH-1:0]   nnz_next;
  logic [ROW_WIDTH-1:0]   row_cnt;
  logic                   ovf;
  logic                   ovf_next;
  logic                   stall;
  logic                   consume;
  logic                   exit_last;
  logic                   exit_empty;

  // A held result freezes the multiplier, the tag pipe and the accumulator together.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign mul_ce   = !stall;

  generate
    if (ACC_WIDTH > PROD_WIDTH) begin : g_ext
      assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){mul_dout[PROD_WIDTH-1]}}, mul_dout};
    end else begin : g_noext
      assign prod_ext = mul_dout;
    end
  endgenerate

  assign exit_last  = tag_last[MUL_LATENCY-1];
  assign exit_empty = tag_empty[MUL_LATENCY-1];
  assign consume    = mul_ce && tag_v[MUL_LATENCY-1];
  assign addend     = exit_empty ? '0 : prod_ext;
  assign acc_next   = acc + addend;
  assign ovf_next   = ovf | ((acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                             (acc_next[ACC_WIDTH-1] != acc[ACC_WIDTH-1]));
  assign nnz_next   = nnz + {{(ROW_WIDTH-1){1'b0}}, !exit_empty};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v     <= '0;
      tag_last  <= '0;
      tag_empty <= '0;
      acc       <= '0;
      nnz       <= '0;
      ovf       <= 1'b0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_row   <= '0;
      out_nnz   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (mul_ce) begin
        tag_v[0]     <= in_valid;
        tag_last[0]  <= in_last;
        tag_empty[0] <= in_valid && in_empty;
        for (int i = 1; i < MUL_LATENCY; i++) begin
          tag_v[i]     <= tag_v[i-1];
          tag_last[i]  <= tag_last[i-1];
          tag_empty[i] <= tag_empty[i-1];
        end
      end
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (consume) begin
        if (exit_last) begin
          out_valid <= 1'b1;
          out_sum   <= acc_next;
          out_row   <= row_cnt;
          out_nnz   <= nnz_next;
          out_ovf   <= ovf_next;
          acc       <= '0;
          nnz       <= '0;
          ovf       <= 1'b0;
          row_cnt   <= row_cnt + 1'b1;
        end else begin
          acc <= acc_next;
          nnz <= nnz_next;
          ovf <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_loop_uhat_sparse_row_acc.sv
// tb/tb_loop_uhat_sparse_row_acc.sv - scoreboard bench for the sparse row accumulator (64- and 54-bit accumulators)
`timescale 1ns/1ps
module tb_loop_uhat_sparse_row_acc;
  localparam int L = 4;
  localparam longint P53M1 = 64'sh001F_FFFF_FFFF_FFFF;
  localparam longint NEG53 = -64'sh0020_0000_0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, in_empty = 1'b0, out_ready = 1'b1;
  logic in_ready, mul_ce, in_ready54, mul_ce54;
  logic [53:0] mul_dout;
  logic out_valid, out_ovf, out_valid54, out_ovf54;
  logic [63:0] out_sum;
  logic [53:0] out_sum54;
  logic [15:0] out_row, out_nnz, out_row54, out_nnz54;
  logic signed [53:0] op_a = '0;
  logic [5:0] op_b = '0;
  logic [53:0] prod_pipe [L];
  int cyc = 0;

  typedef struct {
    logic [63:0] s64;
    logic [53:0] s54;
    logic [15:0] row;
    logic [15:0] nnz;
    logic        o64;
    logic        o54;
  } exp_t;
  exp_t q64[$];
  exp_t q54[$];
  int passed = 0;
  int total = 0;
  int pop_cyc [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 54x6 multiplier, advanced by the accumulator's clock enable.
  always @(posedge clk) begin
    if (mul_ce) begin
      prod_pipe[0] <= 54'(longint'(op_a) * longint'({1'b0, op_b}));
      for (int i = 1; i < L; i++) prod_pipe[i] <= prod_pipe[i-1];
    end
  end
  assign mul_dout = prod_pipe[L-1];

  loop_uhat_sparse_row_acc #(.PROD_WIDTH(54), .ACC_WIDTH(64), .MUL_LATENCY(L), .ROW_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .in_empty(in_empty),
    .in_ready(in_ready), .mul_ce(mul_ce), .mul_dout(mul_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_row(out_row), .out_nnz(out_nnz), .out_ovf(out_ovf));

  loop_uhat_sparse_row_acc #(.PROD_WIDTH(54), .ACC_WIDTH(54), .MUL_LATENCY(L), .ROW_WIDTH(16)) u_dut54 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .in_empty(in_empty),
    .in_ready(in_ready54), .mul_ce(mul_ce54), .mul_dout(mul_dout), .out_valid(out_valid54),
    .out_ready(out_ready), .out_sum(out_sum54), .out_row(out_row54), .out_nnz(out_nnz54), .out_ovf(out_ovf54));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  function automatic void push(input longint s, input int row, input int nnz, input bit o64, input bit o54);
    exp_t e;
    e.s64 = s;
    e.s54 = 54'(s);
    e.row = 16'(row);
    e.nnz = 16'(nnz);
    e.o64 = o64;
    e.o54 = o54;
    q64.push_back(e);
    q54.push_back(e);
  endfunction

  // Monitor: inputs change on the falling edge, so sample just after it.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      if (out_valid && out_ready) begin
        if (q64.size() == 0) begin
          total++;
          $display("FAIL dut64_extra: got row %0d sum %0h, required no result", out_row, out_sum);
        end else begin
          e = q64.pop_front();
          chk("sum64", out_sum, e.s64);
          chk("row64", {48'b0, out_row}, {48'b0, e.row});
          chk("nnz64", {48'b0, out_nnz}, {48'b0, e.nnz});
          chk("ovf64", {63'b0, out_ovf}, {63'b0, e.o64});
          pop_cyc[out_row[3:0]] = cyc;
        end
      end
      if (out_valid54 && out_ready) begin
        if (q54.size() == 0) begin
          total++;
          $display("FAIL dut54_extra: got row %0d sum %0h, required no result", out_row54, out_sum54);
        end else begin
          e = q54.pop_front();
          chk("sum54", {10'b0, out_sum54}, {10'b0, e.s54});
          chk("row54", {48'b0, out_row54}, {48'b0, e.row});
          chk("nnz54", {48'b0, out_nnz54}, {48'b0, e.nnz});
          chk("ovf54", {63'b0, out_ovf54}, {63'b0, e.o54});
        end
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        chk("stall_mul_ce", {63'b0, mul_ce}, 64'd0);
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic elem(input longint a, input int b, input bit last, input bit empty);
    int n = 0;
    op_a = 54'(a);
    op_b = 6'(b);
    in_valid = 1'b1;
    in_last = last;
    in_empty = empty;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_out_row", {48'b0, out_row}, 64'd0);
    chk("rst_out_nnz", {48'b0, out_nnz}, 64'd0);
    chk("rst_out_ovf", {63'b0, out_ovf}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_mul_ce", {63'b0, mul_ce}, 64'd1);
    chk("rst_out_valid54", {63'b0, out_valid54}, 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q64.size() != 0 || q54.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, required 0", q64.size(), q54.size());
    end
    @(negedge clk);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL out_valid_timeout: out_valid stayed 0, required 1");
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Row 0 with latency check
    push(5, 0, 3, 0, 0);
    elem(3, 1, 0, 0);
    elem(-5, 1, 0, 0);
    elem(7, 1, 1, 0);
    for (int k = 1; k < L; k++) begin
      @(negedge clk);
      #1;
      chk("latency_low", {63'b0, out_valid}, 64'd0);
    end
    @(negedge clk);
    #1;
    chk("latency_high", {63'b0, out_valid}, 64'd1);
    repeat (3) @(negedge clk);

    // Back-to-back rows; 2^53 wraps negative in the 54-bit accumulator
    push(64'sh0020_0000_0000_0000, 1, 2, 0, 1);
    push(-1, 2, 1, 0, 0);
    elem(P53M1, 1, 0, 0);
    elem(1, 1, 1, 0);
    elem(-1, 1, 1, 0);

    // Empty row between two {4}; the product 81 of the empty element must be ignored
    push(4, 3, 1, 0, 0);
    push(0, 4, 0, 0, 0);
    push(4, 5, 1, 0, 0);
    elem(4, 1, 1, 0);
    elem(9, 9, 1, 1);
    elem(4, 1, 1, 0);
    drain();

    // Stall for 6 cycles with rows in flight; row 8 has a non-last empty element
    push(30, 6, 2, 0, 0);
    push(-3, 7, 1, 0, 0);
    push(-32, 8, 2, 0, 0);
    out_ready = 1'b0;
    fork
      begin
        wait_out_valid();
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        elem(10, 1, 0, 0);
        elem(20, 1, 1, 0);
        elem(-3, 1, 1, 0);
        elem(5, 2, 0, 0);
        elem(8, 8, 0, 1);
        elem(-7, 6, 1, 0);
      end
    join
    drain();

    // -2^53 twice: wraps to 0 with overflow at 54 bits, then a clean row
    push(-64'sh0040_0000_0000_0000, 9, 2, 0, 1);
    push(4, 10, 1, 0, 0);
    push(273, 11, 2, 0, 0);
    elem(NEG53, 1, 0, 0);
    elem(NEG53, 1, 1, 0);
    elem(4, 1, 1, 0);
    elem(-7, 6, 0, 0);
    elem(5, 63, 1, 0);
    drain();
    chk("consecutive_rows", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);

    // Reset with a pending result and two elements in flight
    out_ready = 1'b0;
    elem(1, 1, 1, 0);
    elem(2, 1, 0, 0);
    elem(3, 1, 0, 0);
    wait_out_valid();
    @(negedge clk);
    reset = 1'b0;
    q64.delete();
    q54.delete();
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    push(6, 0, 1, 0, 0);
    elem(6, 1, 1, 0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
